// File: rtl/aes_decrypt.sv
// ---------------------------------------------------------------------------
// aes_decrypt -- iterative AES-128 inverse cipher, one round per clock.
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous, active-high; clears all state and discards
//                     any partial block
//   valid     in   1  CT/KEY byte pair present this cycle
//   CT        in   8  ciphertext byte, byte 0 (column-major state index 0) first
//   KEY       in   8  AES-128 cipher key byte, same order as CT
//   ready     out  1  registered; high while idle and waiting for a new block
//   pt_valid  out  1  registered; PT carries a plaintext byte
//   PT        out  8  registered plaintext byte, byte 0 first; holds its value
//                     while pt_valid is low
//
// Handshake: valid is a qualifier only; there is no back-pressure. Every
// rising edge in LOAD with valid=1 consumes one CT/KEY pair. ready reports
// "no block in flight": it falls on the edge that takes byte 0 and rises
// again in DONE. Bytes 1..15 are still taken while ready=0, and valid is
// ignored outside LOAD.
//
// Timeline after the edge that takes byte 15: 10 key-expansion cycles
// (forward schedule up to round key 10), 11 decrypt cycles, 16 output cycles,
// 1 DONE cycle. First pt_valid is 22 edges later, ready returns 38 edges
// later.
//
// Submodules (same file): sbox, inv_sbox, inv_mixcolums.
// ---------------------------------------------------------------------------

// Forward AES S-box, used only by the key schedule.
module sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);
  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign result = TABLE[data];
endmodule

// Inverse AES S-box, used by the state path.
module inv_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);
  localparam logic [0:255][7:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign result = TABLE[data];
endmodule

// InvMixColumns for one column. column[r] is the byte in row r.
// Matrix rows: {0e,0b,0d,09} rotated; arithmetic in GF(2^8) mod 0x11b.
module inv_mixcolums (
  input  logic [3:0][7:0] column,
  output logic [3:0][7:0] result
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply b by a 4-bit constant c as a sum of b, 2b, 4b, 8b.
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^
           (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
  endfunction

  assign result[0] = gm(column[0], 4'he) ^ gm(column[1], 4'hb) ^
                     gm(column[2], 4'hd) ^ gm(column[3], 4'h9);
  assign result[1] = gm(column[0], 4'h9) ^ gm(column[1], 4'he) ^
                     gm(column[2], 4'hb) ^ gm(column[3], 4'hd);
  assign result[2] = gm(column[0], 4'hd) ^ gm(column[1], 4'h9) ^
                     gm(column[2], 4'he) ^ gm(column[3], 4'hb);
  assign result[3] = gm(column[0], 4'hb) ^ gm(column[1], 4'hd) ^
                     gm(column[2], 4'h9) ^ gm(column[3], 4'he);
endmodule

module aes_decrypt (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] CT,
  input  logic [7:0] KEY,
  output logic       ready,
  output logic       pt_valid,
  output logic [7:0] PT
);
  typedef enum logic [2:0] {
    LOAD,
    KEY_EXPAND,
    DECRYPTING,
    OUTPUT_PT,
    DONE
  } fsm_t;

  fsm_t fsm_state, fsm_next;

  logic [3:0]       cnt;        // byte index for LOAD and OUTPUT_PT
  logic [3:0]       rnd;        // round index for KEY_EXPAND and DECRYPTING
  logic [15:0][7:0] aes_state;  // cipher state, index = column-major byte
  logic [15:0][7:0] round_key;

  // Key schedule signals
  logic [3:0][7:0]  sched_in;    // RotWord applied to the last key word
  logic [3:0][7:0]  sched_out;
  logic [3:0][7:0]  sched_word;  // SubWord(RotWord(w)) ^ rcon
  logic [7:0]       rcon_sel;
  logic [15:0][7:0] fwd_key;     // next forward round key
  logic [15:0][7:0] inv_key;     // previous round key

  // State path signals
  logic [15:0][7:0] isr;  // InvShiftRows
  logic [15:0][7:0] isb;  // InvSubBytes
  logic [15:0][7:0] ark;  // AddRoundKey with the key being derived this cycle
  logic [15:0][7:0] imc;  // InvMixColumns

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) fsm_state <= LOAD;
    else       fsm_state <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_state;
    case (fsm_state)
      LOAD:       if (valid && cnt == 4'd15) fsm_next = KEY_EXPAND;
      KEY_EXPAND: if (rnd == 4'd9)           fsm_next = DECRYPTING;
      DECRYPTING: if (rnd == 4'd10)          fsm_next = OUTPUT_PT;
      OUTPUT_PT:  if (cnt == 4'd15)          fsm_next = DONE;
      DONE:                                  fsm_next = LOAD;
      default:                               fsm_next = LOAD;
    endcase
  end

  // -------------------------------------------------------------------------
  // Key schedule: one shared set of four S-boxes. Forward expansion feeds
  // them the last word of the current key; the inverse schedule feeds them
  // the last word of the previous key, which is k[12..15] ^ k[8..11].
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (fsm_state == KEY_EXPAND)
        sched_in[i] = round_key[12 + ((i + 1) % 4)];
      else
        sched_in[i] = round_key[12 + ((i + 1) % 4)] ^ round_key[8 + ((i + 1) % 4)];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sched_sbox
    sbox u_sbox (
      .data   (sched_in[g]),
      .result (sched_out[g])
    );
  end

  // Forward expansion in round rnd builds round key rnd+1; inverse schedule
  // in decrypt round rnd recovers round key 10-rnd, which needs rcon[11-rnd].
  always_comb begin
    rcon_sel = (fsm_state == KEY_EXPAND) ? rcon(rnd + 4'd1) : rcon(4'd11 - rnd);

    sched_word    = sched_out;
    sched_word[0] = sched_out[0] ^ rcon_sel;

    for (int i = 0; i < 4; i++) begin
      fwd_key[i]      = round_key[i] ^ sched_word[i];
      fwd_key[4 + i]  = round_key[i] ^ round_key[4 + i] ^ sched_word[i];
      fwd_key[8 + i]  = round_key[i] ^ round_key[4 + i] ^ round_key[8 + i] ^ sched_word[i];
      fwd_key[12 + i] = round_key[i] ^ round_key[4 + i] ^ round_key[8 + i] ^
                        round_key[12 + i] ^ sched_word[i];
    end

    for (int j = 4; j < 16; j++) begin
      inv_key[j] = round_key[j] ^ round_key[j - 4];
    end
    for (int i = 0; i < 4; i++) begin
      inv_key[i] = round_key[i] ^ sched_word[i];
    end
  end

  // -------------------------------------------------------------------------
  // State path: InvShiftRows moves row r right by r columns, so output
  // (row r, col c) comes from column (c - r) mod 4.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < 16; g++) begin : g_state_byte
    localparam int SRC = 4 * (((g / 4) + 4 - (g % 4)) % 4) + (g % 4);
    assign isr[g] = aes_state[SRC];
    inv_sbox u_inv_sbox (
      .data   (isr[g]),
      .result (isb[g])
    );
  end

  assign ark = isb ^ inv_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    inv_mixcolums u_inv_mix (
      .column (ark[4 * c +: 4]),
      .result (imc[4 * c +: 4])
    );
  end

  // -------------------------------------------------------------------------
  // Datapath registers and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      rnd       <= 4'd0;
      ready     <= 1'b1;
      pt_valid  <= 1'b0;
      PT        <= 8'h00;
      aes_state <= '0;
      round_key <= '0;
    end else begin
      case (fsm_state)
        LOAD: begin
          if (valid) begin
            aes_state[cnt] <= CT;
            round_key[cnt] <= KEY;
            cnt            <= cnt + 4'd1;  // wraps to 0 after byte 15
            ready          <= 1'b0;
          end
        end
        KEY_EXPAND: begin
          round_key <= fwd_key;
          rnd       <= (rnd == 4'd9) ? 4'd0 : rnd + 4'd1;
        end
        DECRYPTING: begin
          if (rnd == 4'd0) begin
            aes_state <= aes_state ^ round_key;
          end else if (rnd == 4'd10) begin
            // final round has no InvMixColumns
            aes_state <= ark;
            round_key <= inv_key;
          end else begin
            aes_state <= imc;
            round_key <= inv_key;
          end
          rnd <= (rnd == 4'd10) ? 4'd0 : rnd + 4'd1;
        end
        OUTPUT_PT: begin
          PT       <= aes_state[cnt];
          pt_valid <= 1'b1;
          cnt      <= cnt + 4'd1;
        end
        DONE: begin
          pt_valid <= 1'b0;
          ready    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt -- self-checking bench for aes_decrypt.
// Drives FIPS-197 vectors, gapped input, garbage during processing, reset
// mid-block, back-to-back blocks and random round trips through a
// behavioural AES-128 encryptor built from the standard's definitions.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_decrypt;
  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] CT;
  logic [7:0] KEY;
  logic       ready;
  logic       pt_valid;
  logic [7:0] PT;

  aes_decrypt dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .CT       (CT),
    .KEY      (KEY),
    .ready    (ready),
    .pt_valid (pt_valid),
    .PT       (PT)
  );

  // -------------------------------------------------------------------------
  // Clock / reset block
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sb[256];
  logic [7:0] rc[11];

  // -------------------------------------------------------------------------
  // Reference model: AES-128 forward cipher from the standard's definitions
  // -------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [7:0]  a[4];
    logic [31:0] w[44];
    logic [31:0] x;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      x = w[i - 1];
      if (i % 4 == 0) begin
        x = {x[23:0], x[31:24]};
        x = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]} ^ {rc[i / 4], 24'h000000};
      end
      w[i] = w[i - 4] ^ x;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
        // ShiftRows: row r moves left by r columns
        for (int i = 0; i < 16; i++) s[i] = t[4 * (((i / 4) + (i % 4)) % 4) + (i % 4)];
        if (rd < 10) begin
          for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[4 * c + k];
            s[4 * c]     = gf_mul(a[0], 8'h02) ^ gf_mul(a[1], 8'h03) ^ a[2] ^ a[3];
            s[4 * c + 1] = a[0] ^ gf_mul(a[1], 8'h02) ^ gf_mul(a[2], 8'h03) ^ a[3];
            s[4 * c + 2] = a[0] ^ a[1] ^ gf_mul(a[2], 8'h02) ^ gf_mul(a[3], 8'h03);
            s[4 * c + 3] = gf_mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gf_mul(a[3], 8'h02);
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        x    = w[4 * rd + i / 4];
        s[i] = s[i] ^ x[31 - 8 * (i % 4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = s[i];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks and scoreboard
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bytes(input logic [127:0] ct, input logic [127:0] key,
                            input bit gaps, input int nbytes, input string tag);
    int g;
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && i > 0) begin
        g     = int'($urandom_range(1, 3));
        valid = 1'b0;
        for (int k = 0; k < g; k++) begin
          CT  = 8'($urandom);
          KEY = 8'($urandom);
          tick();
        end
      end
      valid = 1'b1;
      CT    = ct[127 - 8 * i -: 8];
      KEY   = key[127 - 8 * i -: 8];
      tick();
      if (i == 0) check({tag, "_ready_fall"}, 128'(ready), 128'(0));
    end
    valid = 1'b0;
  endtask

  // Called right after the edge that took byte 15. Collects the burst,
  // measures latencies, and returns right after the edge where ready rises.
  task automatic wait_result(input logic [127:0] exp_pt, input bit garbage, input string tag);
    int n, first, last, pv, rdy;
    n = 0; first = -1; last = -1; pv = 0; rdy = -1;
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_pt[127 - 8 * i -: 8]);
    while (n < 80 && rdy < 0) begin
      if (garbage) begin
        valid = 1'b1;
        CT    = 8'($urandom);
        KEY   = 8'($urandom);
      end
      tick();
      n++;
      if (pt_valid) begin
        if (first < 0) first = n;
        last = n;
        pv++;
        if (exp_q.size() > 0) check({tag, "_pt_byte"}, 128'(PT), 128'(exp_q.pop_front()));
      end
      if (ready) rdy = n;
    end
    valid = 1'b0;
    check({tag, "_first_latency"}, 128'(first), 128'(22));
    check({tag, "_ready_latency"}, 128'(rdy), 128'(38));
    check({tag, "_pv_count"}, 128'(pv), 128'(16));
    check({tag, "_pv_span"}, 128'(last - first), 128'(15));
    check({tag, "_bytes_left"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_pt_hold"}, 128'(PT), 128'(exp_pt[7:0]));
    exp_q.delete();
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [7:0]   inv;
    logic [127:0] p, k, c;

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j < 11; j++) rc[j] = gf_mul(rc[j - 1], 8'h02);

    reset = 1'b1;
    valid = 1'b0;
    CT    = 8'h00;
    KEY   = 8'h00;
    tick(); tick(); tick();
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_pt_valid", 128'(pt_valid), 128'(0));
    check("rst_pt", 128'(PT), 128'(0));
    reset = 1'b0;
    tick();
    check("idle_ready", 128'(ready), 128'(1));

    // FIPS-197 C.1, contiguous bytes
    send_bytes(C1_CT, C1_KEY, 1'b0, 16, "c1");
    wait_result(C1_PT, 1'b0, "c1");

    // FIPS-197 Appendix B with 1-3 cycle gaps
    send_bytes(B_CT, B_KEY, 1'b1, 16, "appb");
    wait_result(B_PT, 1'b0, "appb");

    // Garbage with valid high while the block is processed
    send_bytes(C1_CT, C1_KEY, 1'b0, 16, "garbage");
    wait_result(C1_PT, 1'b1, "garbage");

    // Two blocks back-to-back, byte 0 in the first ready cycle
    send_bytes(C1_CT, C1_KEY, 1'b0, 16, "b2b_1");
    wait_result(C1_PT, 1'b0, "b2b_1");
    send_bytes(C1_CT, C1_KEY, 1'b0, 16, "b2b_2");
    wait_result(C1_PT, 1'b0, "b2b_2");

    // Reset during decrypt round 5 (10 expansion edges + 5 rounds)
    send_bytes(C1_CT, C1_KEY, 1'b0, 16, "rst_mid");
    repeat (15) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_ready", 128'(ready), 128'(1));
    check("rst_mid_pt_valid", 128'(pt_valid), 128'(0));
    check("rst_mid_pt", 128'(PT), 128'(0));
    reset = 1'b0;
    send_bytes(C1_CT, C1_KEY, 1'b0, 16, "after_rst");
    wait_result(C1_PT, 1'b0, "after_rst");

    // Reset during a partial load; next byte must be byte 0 again
    send_bytes(B_CT, B_KEY, 1'b0, 5, "partial");
    reset = 1'b1;
    tick();
    check("partial_rst_ready", 128'(ready), 128'(1));
    reset = 1'b0;
    send_bytes(B_CT, B_KEY, 1'b0, 16, "after_partial");
    wait_result(B_PT, 1'b0, "after_partial");

    // Random round trips through the reference encryptor
    for (int b = 0; b < 1000; b++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      c = aes_enc(p, k);
      send_bytes(c, k, 1'b0, 16, "rt");
      wait_result(p, 1'b0, "rt");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
